hex_stream_formatter: RTL

- Downstream of the 16-bit accumulator output stream.
- Converts each accepted binary word into uppercase ASCII hex characters, MSB nibble first, optionally followed by CR LF.
- Emits one character at a time on an 8-bit valid/ready stream for the UART transmitter.
- Lets accumulator results be printed on a serial console.

---
 rtl/hex_stream_formatter_if.sv | 33 +++
 rtl/hex_stream_formatter.sv | 118 +++++++++++
 2 files changed

// File: rtl/hex_stream_formatter_if.sv
// Stream bundle for hex_stream_formatter.
//   Word side (into the formatter):  input_valid, input_ready, input_data
//   Char side (out of the formatter): output_valid, output_ready, output_data
// slave  : used by the formatter itself.
// master : used by whatever drives words in and takes characters out.
interface hex_stream_formatter_if #(
  parameter int INPUT_WIDTH = 16
);
  logic                   input_valid;
  logic                   input_ready;
  logic [INPUT_WIDTH-1:0] input_data;
  logic                   output_valid;
  logic                   output_ready;
  logic [7:0]             output_data;

  modport slave (
    input  input_valid,
    input  input_data,
    input  output_ready,
    output input_ready,
    output output_valid,
    output output_data
  );

  modport master (
    output input_valid,
    output input_data,
    output output_ready,
    input  input_ready,
    input  output_valid,
    input  output_data
  );
endinterface

// File: rtl/hex_stream_formatter.sv
// Converts each accepted binary word into uppercase ASCII hex characters,
// MSB nibble first, optionally followed by CR LF, one character per transfer.
// Ports:
//   clock  - clock, all state on the rising edge
//   reset  - synchronous, active-high
//   bus    - word input stream and 8-bit character output stream (slave side)
//   busy   - high while a character is being presented (equals output_valid)
// INPUT_WIDTH must be a multiple of 4 and at least 4.
module hex_stream_formatter #(
  parameter int INPUT_WIDTH = 16,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  hex_stream_formatter_if.slave   bus,
  output logic                    busy
);

  localparam int NUM_DIGITS = INPUT_WIDTH / 4;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGIT,
    S_CR,
    S_LF
  } state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    // 'A' (0x41) is 0x37 + 10
    if (n < 4'd10) nibble_to_ascii = 8'h30 + {4'h0, n};
    else           nibble_to_ascii = 8'h37 + {4'h0, n};
  endfunction

  state_t                 state_p1, state_nx;
  logic [CNT_W-1:0]       digit_cnt_p1, digit_cnt_nx;
  logic [INPUT_WIDTH-1:0] shift_p1, shift_nx;
  logic [INPUT_WIDTH-1:0] shift_next_digit;
  logic [7:0]             char_p1, char_nx;
  logic                   vld_p1;
  logic                   last_char;
  logic                   accept;
  logic                   out_xfer;

  assign vld_p1   = (state_p1 != S_IDLE);
  assign out_xfer = vld_p1 && bus.output_ready;

  // The final character of a message is LF, or the last digit when no CR LF
  // is appended; its transfer frees the block to take the next word at once.
  always_comb begin
    last_char = 1'b0;
    if (APPEND_CRLF) last_char = (state_p1 == S_LF);
    else             last_char = (state_p1 == S_DIGIT) && (digit_cnt_p1 == LAST_DIGIT);
  end

  assign bus.input_ready = !reset && (!vld_p1 || (bus.output_ready && last_char));
  assign accept          = bus.input_valid && bus.input_ready;

  // Remaining digits are kept left-aligned so the current one is always the top nibble.
  assign shift_next_digit = shift_p1 << 4;

  always_comb begin
    state_nx     = state_p1;
    digit_cnt_nx = digit_cnt_p1;
    shift_nx     = shift_p1;
    char_nx      = char_p1;
    if (accept) begin
      state_nx     = S_DIGIT;
      digit_cnt_nx = '0;
      shift_nx     = bus.input_data;
      char_nx      = nibble_to_ascii(bus.input_data[INPUT_WIDTH-1 -: 4]);
    end else if (out_xfer) begin
      case (state_p1)
        S_DIGIT: begin
          if (digit_cnt_p1 == LAST_DIGIT) begin
            if (APPEND_CRLF) begin
              state_nx = S_CR;
              char_nx  = 8'h0D;
            end else begin
              state_nx = S_IDLE;
            end
          end else begin
            digit_cnt_nx = digit_cnt_p1 + CNT_W'(1);
            shift_nx     = shift_next_digit;
            char_nx      = nibble_to_ascii(shift_next_digit[INPUT_WIDTH-1 -: 4]);
          end
        end
        S_CR: begin
          state_nx = S_LF;
          char_nx  = 8'h0A;
        end
        S_LF:    state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Stage p1: presented character and message progress
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p1     <= S_IDLE;
      digit_cnt_p1 <= '0;
      shift_p1     <= '0;
      char_p1      <= 8'h00;
    end else begin
      state_p1     <= state_nx;
      digit_cnt_p1 <= digit_cnt_nx;
      shift_p1     <= shift_nx;
      char_p1      <= char_nx;
    end
  end

  assign bus.output_valid = vld_p1;
  assign bus.output_data  = char_p1;
  assign busy             = vld_p1;

endmodule
